// File: rtl/accel_pkg.sv
// ============================================================================
// Module      : accel_pkg
// Description : Shared constants and accelerator ID encoding for the
//               router and its accelerator FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accel_pkg;

    localparam int ACC_WIDTH      = 32;
    localparam int ACC_FIFO_DEPTH = 16;
    localparam int ACC_FIFO_AW    = 4;

    typedef enum logic [1:0] {
        ACC_FFT = 2'd0,
        ACC_FIR = 2'd1,
        ACC_IIR = 2'd2
    } acc_id_t;

    function automatic logic acc_id_is_valid(input logic [1:0] id);
        return (id == ACC_FFT) || (id == ACC_FIR) || (id == ACC_IIR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/accel_fifo_mem.sv
// ============================================================================
// Module      : accel_fifo_mem
// Description : DEPTH x WIDTH register file, one synchronous write port and
//               one asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_fifo_mem
    import accel_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int DEPTH = ACC_FIFO_DEPTH,
    parameter int AW    = ACC_FIFO_AW
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/accel_fifo.sv
// ============================================================================
// Module      : accel_fifo
// Description : Synchronous FIFO between the router and one accelerator, with
//               registered read data. Define ACCEL_FIFO_ERR_EN to add sticky
//               overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_fifo
    import accel_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int DEPTH = ACC_FIFO_DEPTH,
    parameter int AW    = ACC_FIFO_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             put_req,
    input  logic [WIDTH-1:0] data_in,
    input  logic             get_req,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
`ifdef ACCEL_FIFO_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_data_out;

    logic             w_full;
    logic             w_empty;
    logic             w_get_acc;
    logic             w_put_acc;
    logic [WIDTH-1:0] w_rdata;

    // Flags come only from the registered count, never from the strobes.
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_get_acc = get_req & ~w_empty;
    // A full FIFO still takes a put when the same edge frees a slot.
    assign w_put_acc = put_req & (~w_full | w_get_acc);

    accel_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_put_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            if (w_put_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_get_acc) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= w_rdata;
            end
            case ({w_put_acc, w_get_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ACCEL_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (put_req & w_full & ~w_get_acc) begin
                r_overflow <= 1'b1;
            end
            if (get_req & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_accel_fifo.sv
// ============================================================================
// Module      : tb_accel_fifo
// Description : Scoreboard bench for accel_fifo against a queue-based model;
//               also covers ACCEL_FIFO_ERR_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_fifo;

    localparam int W = 32;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          put_req = 1'b0;
    logic          get_req = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic          full;
    logic          empty;
    logic [4:0]    count;
`ifdef ACCEL_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    accel_fifo #(.WIDTH(W), .DEPTH(D), .AW(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .put_req  (put_req),
        .data_in  (data_in),
        .get_req  (get_req),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef ACCEL_FIFO_ERR_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents, expected read words, sticky flags.
    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_hold = '0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, W'(count), W'(mq.size()));
        chk({tag, "_full"},  W'(full),  W'(mq.size() == D));
        chk({tag, "_empty"}, W'(empty), W'(mq.size() == 0));
`ifdef ACCEL_FIFO_ERR_EN
        chk({tag, "_ovf"},   W'(overflow),  W'(m_ovf));
        chk({tag, "_unf"},   W'(underflow), W'(m_unf));
`endif
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic cycle(input logic p, input logic [W-1:0] d, input logic g);
        logic m_get;
        logic m_put;
        put_req = p;
        data_in = d;
        get_req = g;
        m_get = g && (mq.size() > 0);
        m_put = p && ((mq.size() < D) || m_get);
        if (p && (mq.size() == D) && !m_get) m_ovf = 1'b1;
        if (g && (mq.size() == 0)) m_unf = 1'b1;
        if (m_get) exp_q.push_back(mq.pop_front());
        if (m_put) mq.push_back(d);
        @(posedge clk);
        #1;
        chk_state("cyc");
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic reset_mid();
        put_req = 1'b0;
        get_req = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        mq.delete();
        exp_q.delete();
        exp_hold = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("rst_data_out", data_out, '0);
        chk_state("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_state("post_rst");
    endtask

    // Monitor: a get accepted on this edge presents its word on data_out.
    logic mon_took;
    always @(posedge clk) begin
        mon_took = reset && get_req && !empty;
        #1;
        if (reset) begin
            if (mon_took) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_read", data_out, exp_hold);
                    n_fail++;
                    $display("FAIL sb_underrun @%0t: read with empty scoreboard, data_out 0x%0h", $time, data_out);
                end else begin
                    exp_hold = exp_q.pop_front();
                    chk("data_out", data_out, exp_hold);
                end
            end else begin
                chk("data_out_hold", data_out, exp_hold);
            end
        end
    end

    initial begin
        #2;
        reset = 1'b0;
        #1;
        chk("init_data_out", data_out, '0);
        chk_state("init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Fill, dropped 17th put, drain.
        for (int i = 1; i <= 16; i++) cycle(1'b1, W'(i), 1'b0);
        cycle(1'b1, 32'hDEAD, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Wrap-around: 8 in, 8 out, five rounds.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0);
            for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        end
        cycle(1'b0, '0, 1'b0);

        // Simultaneous access at empty and at full.
        cycle(1'b1, 32'hA5, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, $urandom, 1'b0);
        cycle(1'b1, 32'h77, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Reset with words queued, then a fresh put/get.
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0);
        reset_mid();
        cycle(1'b1, 32'h3C, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Error conditions: get on empty, put on full without get.
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, $urandom, 1'b0);
        cycle(1'b1, 32'hBAD, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        reset_mid();

        // Random traffic with alternating fill/drain bias.
        for (int ph = 0; ph < 12; ph++) begin
            int pp;
            pp = (ph % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 50; i++) begin
                cycle(($urandom_range(99) < pp) ? 1'b1 : 1'b0, $urandom,
                      ($urandom_range(99) < (100 - pp)) ? 1'b1 : 1'b0);
            end
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);

        chk("sb_drained", W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
